fetch_ifid: RTL and testbench
=============================

# fetch_ifid

Fetch stage plus IF/ID pipeline register for the five-stage WISC pipeline. The block owns the PC and issues requests to instruction memory, and it presents the fetched instruction to decode. It consumes the `stall` produced by the decode-stage hazard unit to freeze the front end. It also consumes branch/jump redirects from later stages, which flush the IF/ID register.

## Interface
Parameters:
- `RESET_PC`, 16'h0000: PC value loaded on reset.
- `NOP_INSTR`, 16'h0800: encoding injected into IF/ID on flush or bubble.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `stall`  in  1: hazard-unit stall; freezes PC and IF/ID.
- `redirect`  in  1: taken branch/jump resolved downstream.
- `redirect_pc`  in  16: target PC, valid with `redirect`.
- `imem_en`  out  1: instruction memory request.
- `imem_addr`  out  16: request address, registered.
- `imem_data`  in  16: returned instruction, valid with `imem_done`.
- `imem_done`  in  1: memory response this cycle (single-cycle memory ties it to 1).
- `instr_d`  out  16: IF/ID instruction to decode.
- `pc2_d`  out  16: IF/ID PC+2, used for JAL/JALR link and branch base.
- `valid_d`  out  1: IF/ID holds a real instruction.
- `halted`  out  1: fetch stopped on HALT.

## Operation
- States are RUN, WAIT, and HALTED, with a one-bit `drop` flag.
- RUN:
  - `imem_en`=1.
  - If `imem_done`=1 and `stall`=0: capture `imem_data` into IF/ID, set `valid_d`=1 and `pc2_d`=req+2, and advance PC to req+2.
  - If `imem_done`=0: go to WAIT and load NOP into IF/ID. A bubble is emitted unless `stall` is high, in which case IF/ID is held.
- WAIT:
  - `imem_addr` is held stable.
  - On `imem_done`, behave as RUN-capture and return to RUN.
- Stall with `imem_done`=1: the response is discarded, PC and IF/ID hold, and the same address is re-requested next cycle.
- Redirect has priority over stall:
  - IF/ID is loaded with `NOP_INSTR`, `valid_d`=0, and PC is set to `redirect_pc`.
  - In RUN, the next request goes to the target.
  - In WAIT, `drop` is set. When `imem_done` arrives, the response is discarded, `drop` clears, and the target is requested next cycle.
- HALT is opcode 5'b00000:
  - On capture of a HALT, IF/ID holds HALT for decode, then the block enters HALTED.
  - HALTED: `imem_en`=0, PC frozen, IF/ID fed NOP, `halted`=1.
  - A redirect in HALTED returns the block to RUN, because the HALT was in a squashed shadow.
- PC arithmetic is 16-bit modulo: 16'hFFFE+2 wraps to 16'h0000 with no flag.

## Timing
- Reset values:
  - PC=`RESET_PC`, `imem_addr`=`RESET_PC`, `imem_en`=0 during the reset cycle.
  - `instr_d`=`NOP_INSTR`, `pc2_d`=0, `valid_d`=0, `halted`=0, `drop`=0.
  - State=RUN.
- The first request (`imem_en`=1) is issued in the cycle after `rst` deasserts.
- Fetch latency: the instruction appears on `instr_d` one cycle after the `imem_done` cycle. With single-cycle memory the throughput is 1 instruction/cycle.
- Redirect: the target instruction appears in `instr_d` two cycles after the `redirect` cycle (single-cycle memory). Exactly one NOP is seen in between.
- Reset during WAIT or HALTED returns to the reset state immediately. Any late `imem_done` is ignored in the reset cycle only.
- Simultaneous `redirect` and `stall`: the redirect wins.
- Simultaneous `redirect` and HALT capture: the redirect wins and the HALT is not captured.

## Configuration
- `FETCH_PERF_CNT_EN`: when defined, adds three 16-bit saturating counters, reset to 0:
  - `perf_stall_cnt`: cycles with `stall`=1.
  - `perf_flush_cnt`: redirect cycles.
  - `perf_wait_cnt`: cycles in WAIT.
  - The three are exposed as extra outputs.
- When the macro is undefined, neither the counters nor their ports exist. Behaviour is otherwise identical.

## Structure
- The shared package holds:
  - State encoding: RUN=2'd0, WAIT=2'd1, HALTED=2'd2.
  - `NOP_INSTR` and `HALT_OPCODE` constants.
  - 16-bit word width.
- One sub-module, `ifid_reg`: the IF/ID register with load-enable (hold on stall) and synchronous flush-to-NOP.
- PC, FSM and request logic live in the top module.

## Test plan
- Reset, then single-cycle memory returning 16'hC001, 16'hC102, 16'hC203 → `instr_d` follows one cycle later, `pc2_d`=2, 4, 6, `valid_d`=1.
- `stall`=1 for 2 cycles at PC=4 → `instr_d` and `pc2_d` hold, `imem_addr` stays 4, and fetch resumes at 4 with no instruction skipped or duplicated.
- `redirect`=1 with `redirect_pc`=16'h0040 while `stall`=1 → next `instr_d`=16'h0800 with `valid_d`=0, then `imem_addr`=16'h0040.
- `imem_done` held low 3 cycles, `redirect` to 16'h0100 in the 2nd → the late response is dropped, and the next request is 16'h0100.
- Memory returns 16'h0000 → `instr_d`=16'h0000, then `halted`=1 and `imem_en`=0. A subsequent `redirect` to 16'h0010 resumes fetch.
- PC at 16'hFFFE → next `imem_addr`=16'h0000. `rst` asserted mid-WAIT → all outputs at reset values the next cycle.

Source files
------------

// File: rtl/fetch_ifid_pkg.sv
// Shared definitions for the WISC fetch stage and its IF/ID register:
// word width, FSM state encoding, NOP / HALT encodings and a HALT decoder.
package fetch_ifid_pkg;

   localparam int WORD_W = 16;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_WAIT   = 2'd1,
      ST_HALTED = 2'd2
   } state_e;

   localparam word_t      NOP_INSTR   = 16'h0800;
   localparam logic [4:0] HALT_OPCODE = 5'b00000;

   // HALT is recognised purely on the 5-bit opcode field.
   function automatic logic is_halt(input word_t instr);
      return instr[15:11] == HALT_OPCODE;
   endfunction

endpackage

// File: rtl/fetch_ifid_ifid_reg.sv
// IF/ID pipeline register. Priority: reset > flush (load NOP, invalid) >
// load (capture fetched word) > hold. pc2_d is left untouched by a flush
// because an invalid slot's link value is never consumed.
module ifid_reg #(
   parameter logic [15:0] NOP_INSTR = 16'h0800
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        flush,
   input  logic [15:0] instr_in,
   input  logic [15:0] pc2_in,
   output logic [15:0] instr_d,
   output logic [15:0] pc2_d,
   output logic        valid_d
);

   // Pipeline register update with synchronous reset and flush-to-NOP.
   always_ff @(posedge clk) begin
      if (rst) begin
         instr_d <= NOP_INSTR;
         pc2_d   <= 16'h0000;
         valid_d <= 1'b0;
      end else if (flush) begin
         instr_d <= NOP_INSTR;
         valid_d <= 1'b0;
      end else if (load) begin
         instr_d <= instr_in;
         pc2_d   <= pc2_in;
         valid_d <= 1'b1;
      end
   end

endmodule

// File: rtl/fetch_ifid.sv
// Fetch stage + IF/ID register for the five-stage WISC pipeline.
// Owns the PC, issues instruction-memory requests, handles stall, redirect
// (with drop of an in-flight response) and HALT.
// Optional build macro FETCH_PERF_CNT_EN adds three saturating 16-bit
// performance counters (stall cycles, redirect cycles, WAIT cycles).
//
// Memory handshake: a request is outstanding whenever imem_en=1; imem_addr
// stays constant until the cycle in which imem_done=1 is seen, and that
// cycle's imem_data is the response to imem_addr.
module fetch_ifid #(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter logic [15:0] NOP_INSTR = 16'h0800
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic        imem_en,
   output logic [15:0] imem_addr,
   input  logic [15:0] imem_data,
   input  logic        imem_done,
   output logic [15:0] instr_d,
   output logic [15:0] pc2_d,
   output logic        valid_d,
   output logic        halted,
   output logic [1:0]  dbg_state
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [15:0] perf_stall_cnt,
   output logic [15:0] perf_flush_cnt,
   output logic [15:0] perf_wait_cnt
`endif
);

   import fetch_ifid_pkg::*;

   state_e state_q, state_n;
   logic   drop_q, drop_n;
   word_t  pc_q, pc_n;
   word_t  addr_q, addr_n;
   word_t  pc_plus2;
   logic   capture;
   logic   flush;

   // pc_q is where fetch resumes; addr_q differs from it only while a
   // redirect waits for a stale response to drain in WAIT.
   assign pc_plus2  = addr_q + 16'd2;
   assign imem_addr = addr_q;
   assign dbg_state = state_q;

   // State, drop flag, PC and request-address registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
         drop_q  <= 1'b0;
         pc_q    <= RESET_PC;
         addr_q  <= RESET_PC;
      end else begin
         state_q <= state_n;
         drop_q  <= drop_n;
         pc_q    <= pc_n;
         addr_q  <= addr_n;
      end
   end

   // Next-state, drop flag and next PC / address selection.
   always_comb begin
      state_n = state_q;
      drop_n  = drop_q;
      case (state_q)
         ST_RUN: begin
            if (redirect)
               state_n = ST_RUN;
            else if (!imem_done)
               state_n = ST_WAIT;
            else if (capture && is_halt(imem_data))
               state_n = ST_HALTED;
         end
         ST_WAIT: begin
            if (redirect) begin
               // A response arriving now is the stale one; otherwise drop the next.
               if (imem_done) begin
                  state_n = ST_RUN;
                  drop_n  = 1'b0;
               end else begin
                  drop_n  = 1'b1;
               end
            end else if (imem_done) begin
               drop_n  = 1'b0;
               state_n = (capture && is_halt(imem_data)) ? ST_HALTED : ST_RUN;
            end
         end
         ST_HALTED: begin
            if (redirect) begin
               state_n = ST_RUN;
               drop_n  = 1'b0;
            end
         end
         default: begin
            state_n = ST_RUN;
            drop_n  = 1'b0;
         end
      endcase

      if (redirect)
         pc_n = redirect_pc;
      else if (capture)
         pc_n = pc_plus2;
      else
         pc_n = pc_q;

      // The request address must not move while a request is outstanding.
      addr_n = (state_n == ST_WAIT) ? addr_q : pc_n;
   end

   // Outputs and IF/ID control derived from the current state and inputs.
   always_comb begin
      imem_en = !rst && (state_q != ST_HALTED);
      halted  = (state_q == ST_HALTED);
      capture = (state_q != ST_HALTED) && imem_done && !stall && !redirect &&
                !((state_q == ST_WAIT) && drop_q);
      // Whatever is neither captured nor frozen by stall becomes a bubble.
      flush   = redirect || (!stall && !capture);
   end

   ifid_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_ifid_reg (
      .clk      (clk),
      .rst      (rst),
      .load     (capture),
      .flush    (flush),
      .instr_in (imem_data),
      .pc2_in   (pc_plus2),
      .instr_d  (instr_d),
      .pc2_d    (pc2_d),
      .valid_d  (valid_d)
   );

`ifdef FETCH_PERF_CNT_EN
   // Saturating event counters for stall, redirect and WAIT cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_stall_cnt <= 16'h0000;
         perf_flush_cnt <= 16'h0000;
         perf_wait_cnt  <= 16'h0000;
      end else begin
         if (stall && (perf_stall_cnt != 16'hFFFF))
            perf_stall_cnt <= perf_stall_cnt + 16'd1;
         if (redirect && (perf_flush_cnt != 16'hFFFF))
            perf_flush_cnt <= perf_flush_cnt + 16'd1;
         if ((state_q == ST_WAIT) && (perf_wait_cnt != 16'hFFFF))
            perf_wait_cnt <= perf_wait_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_ifid.sv
// Self-checking bench for fetch_ifid: directed cycle table, each row gives
// the memory/hazard inputs, the request expected on the memory port, and the
// IF/ID contents expected after the edge (pushed to a scoreboard queue).
module tb_fetch_ifid;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        imem_en;
   logic [15:0] imem_addr;
   logic [15:0] imem_data;
   logic        imem_done;
   logic [15:0] instr_d;
   logic [15:0] pc2_d;
   logic        valid_d;
   logic        halted;
   logic [1:0]  dbg_state;
`ifdef FETCH_PERF_CNT_EN
   logic [15:0] perf_stall_cnt;
   logic [15:0] perf_flush_cnt;
   logic [15:0] perf_wait_cnt;
`endif

   int n_vec = 0;
   int n_err = 0;

   // {valid, pc2, instr}
   logic [32:0] exp_q[$];
   localparam logic [32:0] BUB = {1'b0, 16'h0000, 16'h0800};

   fetch_ifid dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_en     (imem_en),
      .imem_addr   (imem_addr),
      .imem_data   (imem_data),
      .imem_done   (imem_done),
      .instr_d     (instr_d),
      .pc2_d       (pc2_d),
      .valid_d     (valid_d),
      .halted      (halted),
      .dbg_state   (dbg_state)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_stall_cnt (perf_stall_cnt),
      .perf_flush_cnt (perf_flush_cnt),
      .perf_wait_cnt  (perf_wait_cnt)
`endif
   );

   // Clock and watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [32:0] ifv(input logic [15:0] instr, input logic [15:0] pc2);
      return {1'b1, pc2, instr};
   endfunction

   // One cycle: drive inputs, check the request, then check IF/ID after the edge.
   task automatic step(input logic st, input logic rd, input logic [15:0] rpc,
                       input logic dn, input logic [15:0] dat,
                       input logic [15:0] e_addr, input logic e_en,
                       input logic [32:0] e_ifid);
      logic [32:0] e;
      stall       = st;
      redirect    = rd;
      redirect_pc = rpc;
      imem_done   = dn;
      imem_data   = dat;
      exp_q.push_back(e_ifid);
      #1;
      check("imem_addr", 32'(imem_addr), 32'(e_addr));
      check("imem_en", 32'(imem_en), 32'(e_en));
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check("instr_d", 32'(instr_d), 32'(e[15:0]));
      check("valid_d", 32'(valid_d), 32'(e[32]));
      if (e[32])
         check("pc2_d", 32'(pc2_d), 32'(e[31:16]));
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_instr"}, 32'(instr_d), 32'h0800);
      check({tag, "_pc2"}, 32'(pc2_d), 32'h0000);
      check({tag, "_valid"}, 32'(valid_d), 32'd0);
      check({tag, "_halted"}, 32'(halted), 32'd0);
      check({tag, "_addr"}, 32'(imem_addr), 32'h0000);
      check({tag, "_state"}, 32'(dbg_state), 32'd0);
   endtask

   initial begin
      rst         = 1'b1;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 16'h0000;
      imem_done   = 1'b0;
      imem_data   = 16'h0000;

      // Reset
      @(negedge clk);
      check("en_in_reset", 32'(imem_en), 32'd0);
      check_reset_outputs("reset");
      rst = 1'b0;

      // Single-cycle fetch stream, then a two-cycle stall at PC=4
      step(0, 0, 16'h0000, 1, 16'hC001, 16'h0000, 1, ifv(16'hC001, 16'h0002));
      step(0, 0, 16'h0000, 1, 16'hC102, 16'h0002, 1, ifv(16'hC102, 16'h0004));
      step(1, 0, 16'h0000, 1, 16'hC203, 16'h0004, 1, ifv(16'hC102, 16'h0004));
      step(1, 0, 16'h0000, 1, 16'hC203, 16'h0004, 1, ifv(16'hC102, 16'h0004));
      step(0, 0, 16'h0000, 1, 16'hC203, 16'h0004, 1, ifv(16'hC203, 16'h0006));
      step(0, 0, 16'h0000, 1, 16'hC304, 16'h0006, 1, ifv(16'hC304, 16'h0008));

      // Redirect wins over stall; exactly one NOP, then the target
      step(1, 1, 16'h0040, 1, 16'hC405, 16'h0008, 1, BUB);
      step(0, 0, 16'h0000, 1, 16'hC040, 16'h0040, 1, ifv(16'hC040, 16'h0042));

      // Slow memory: redirect during WAIT drops the late response
      step(0, 0, 16'h0000, 0, 16'h0000, 16'h0042, 1, BUB);
      check("state_wait", 32'(dbg_state), 32'd1);
      step(0, 1, 16'h0100, 0, 16'h0000, 16'h0042, 1, BUB);
      step(0, 0, 16'h0000, 0, 16'h0000, 16'h0042, 1, BUB);
      step(0, 0, 16'h0000, 1, 16'hC0DE, 16'h0042, 1, BUB);
      step(0, 0, 16'h0000, 1, 16'hC100, 16'h0100, 1, ifv(16'hC100, 16'h0102));

      // Plain WAIT then capture
      step(0, 0, 16'h0000, 0, 16'h0000, 16'h0102, 1, BUB);
      step(0, 0, 16'h0000, 1, 16'hC55A, 16'h0102, 1, ifv(16'hC55A, 16'h0104));

      // HALT capture, HALTED, redirect out of HALTED
      step(0, 0, 16'h0000, 1, 16'h0000, 16'h0104, 1, ifv(16'h0000, 16'h0106));
      check("halted_set", 32'(halted), 32'd1);
      check("state_halted", 32'(dbg_state), 32'd2);
      step(0, 0, 16'h0000, 0, 16'h0000, 16'h0106, 0, BUB);
      step(0, 0, 16'h0000, 1, 16'hC777, 16'h0106, 0, BUB);
      check("halted_hold", 32'(halted), 32'd1);
      step(0, 1, 16'h0010, 0, 16'h0000, 16'h0106, 0, BUB);
      check("halted_clear", 32'(halted), 32'd0);
      step(0, 0, 16'h0000, 1, 16'hC010, 16'h0010, 1, ifv(16'hC010, 16'h0012));

      // Redirect beats a simultaneous HALT capture
      step(0, 1, 16'h0020, 1, 16'h0000, 16'h0012, 1, BUB);
      check("halt_squashed", 32'(halted), 32'd0);
      check("state_run", 32'(dbg_state), 32'd0);
      step(0, 0, 16'h0000, 1, 16'hC020, 16'h0020, 1, ifv(16'hC020, 16'h0022));

      // PC wrap at 16'hFFFE
      step(0, 1, 16'hFFFE, 1, 16'hC022, 16'h0022, 1, BUB);
      step(0, 0, 16'h0000, 1, 16'hCFFE, 16'hFFFE, 1, ifv(16'hCFFE, 16'h0000));
      step(0, 0, 16'h0000, 1, 16'hC000, 16'h0000, 1, ifv(16'hC000, 16'h0002));

      // Reset in the middle of WAIT, with a late response in the reset cycle
      step(0, 0, 16'h0000, 0, 16'h0000, 16'h0002, 1, BUB);
      check("state_wait2", 32'(dbg_state), 32'd1);
      rst       = 1'b1;
      imem_done = 1'b1;
      imem_data = 16'hC0BB;
      #1;
      check("en_in_reset2", 32'(imem_en), 32'd0);
      @(posedge clk);
      #1;
      check_reset_outputs("reset_wait");
      @(negedge clk);
      rst = 1'b0;
      step(0, 0, 16'h0000, 1, 16'hC0AA, 16'h0000, 1, ifv(16'hC0AA, 16'h0002));

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
